// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 codes, access sizes, FSM states and
// the latched request control fields.
package lsu_pkg;

  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_D  = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_WU = 3'b110;

  localparam logic [3:0] BYTES_B = 4'd1;
  localparam logic [3:0] BYTES_H = 4'd2;
  localparam logic [3:0] BYTES_W = 4'd4;
  localparam logic [3:0] BYTES_D = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic [FUNCT3_W-1:0] funct3;
    logic [OFFSET_W-1:0] offset;
  } lsu_ctrl_t;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic logic [3:0] access_bytes(input logic [FUNCT3_W-1:0] funct3);
    logic [3:0] bytes;
    case (funct3[1:0])
      2'd0:    bytes = BYTES_B;
      2'd1:    bytes = BYTES_H;
      2'd2:    bytes = BYTES_W;
      default: bytes = BYTES_D;
    endcase
    return bytes;
  endfunction

  function automatic logic is_legal(input logic write, input logic [FUNCT3_W-1:0] funct3);
    return write ? (funct3 <= F3_D) : (funct3 <= F3_WU);
  endfunction

  function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] funct3,
                                         input logic [OFFSET_W-1:0] offset);
    logic [3:0] low_mask;
    low_mask = access_bytes(funct3) - 4'd1;
    return |(offset & low_mask[OFFSET_W-1:0]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic: load extraction with zero/sign extension and
// read-modify-write merge of store bytes into the old memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [WORDSIZE-1:0] rd_word,
  input  logic [WORDSIZE-1:0] wdata,
  output logic [WORDSIZE-1:0] load_data,
  output logic [WORDSIZE-1:0] store_word
);

  localparam int unsigned SHIFT_W = OFFSET_W + 3;

  logic [SHIFT_W-1:0]  bit_shift;
  logic [WORDSIZE-1:0] shifted;
  logic [WORDSIZE-1:0] lane_mask;
  logic [WORDSIZE-1:0] mask;

  assign bit_shift = {offset, 3'b000};
  assign shifted   = rd_word >> bit_shift;

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{(WORDSIZE-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(WORDSIZE-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(WORDSIZE-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = WORDSIZE'(shifted[7:0]);
      F3_HU:   load_data = WORDSIZE'(shifted[15:0]);
      F3_WU:   load_data = WORDSIZE'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

  // Byte-lane mask of the store, positioned at the byte offset.
  always_comb begin
    lane_mask = '1;
    case (funct3[1:0])
      2'd0:    lane_mask = WORDSIZE'(8'hFF);
      2'd1:    lane_mask = WORDSIZE'(16'hFFFF);
      2'd2:    lane_mask = WORDSIZE'(32'hFFFF_FFFF);
      default: lane_mask = '1;
    endcase
  end

  assign mask       = lane_mask << bit_shift;
  assign store_word = (rd_word & ~mask) | ((wdata << bit_shift) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned SIZE     = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_error,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_data_input,
  output logic                mem_write_en,
  input  logic [WORDSIZE-1:0] mem_data_output
);

  localparam int unsigned IDX_W = WORDSIZE - OFFSET_W;

  lsu_state_e          state, state_next;
  lsu_ctrl_t           ctrl_q, ctrl_next;
  logic [IDX_W-1:0]    idx_q, idx_next;
  logic [WORDSIZE-1:0] wdata_q, wdata_next;

  logic                req_ready_next;
  logic                resp_valid_next;
  logic                resp_error_next;
  logic [WORDSIZE-1:0] resp_rdata_next;
  logic [WORDSIZE-1:0] mem_addr_next;
  logic [WORDSIZE-1:0] mem_data_input_next;
  logic                mem_write_en_next;

  logic [IDX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0] req_offset;
  logic                req_error;
  logic [WORDSIZE-1:0] load_data;
  logic [WORDSIZE-1:0] store_word;

  assign req_idx    = req_addr[WORDSIZE-1:OFFSET_W];
  assign req_offset = req_addr[OFFSET_W-1:0];
  assign req_error  = !is_legal(req_write, req_funct3)
                    || is_misaligned(req_funct3, req_offset)
                    || (req_idx >= IDX_W'(SIZE));

  lsu_align #(.WORDSIZE(WORDSIZE)) u_align (
    .funct3     (ctrl_q.funct3),
    .offset     (ctrl_q.offset),
    .rd_word    (mem_data_output),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_next          = state;
    ctrl_next           = ctrl_q;
    idx_next            = idx_q;
    wdata_next          = wdata_q;
    resp_valid_next     = 1'b0;
    resp_error_next     = 1'b0;
    resp_rdata_next     = '0;
    mem_data_input_next = '0;
    mem_write_en_next   = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          ctrl_next.funct3 = req_funct3;
          ctrl_next.offset = req_offset;
          idx_next         = req_idx;
          wdata_next       = req_wdata;
          if (req_error) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
          end else if (!req_write) begin
            state_next = LOAD;
          end else if (req_funct3 == F3_D) begin
            state_next          = STORE_WR;
            mem_write_en_next   = 1'b1;
            mem_data_input_next = req_wdata;
          end else begin
            state_next = STORE_RD;
          end
        end
      end
      LOAD: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_data;
      end
      STORE_RD: begin
        state_next          = STORE_WR;
        mem_write_en_next   = 1'b1;
        mem_data_input_next = store_word;
      end
      STORE_WR: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    req_ready_next = (state_next == IDLE);
    mem_addr_next  = (state_next == IDLE) ? '0 : WORDSIZE'(idx_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ctrl_q         <= '0;
      idx_q          <= '0;
      wdata_q        <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_addr       <= '0;
      mem_data_input <= '0;
      mem_write_en   <= 1'b0;
    end else begin
      state          <= state_next;
      ctrl_q         <= ctrl_next;
      idx_q          <= idx_next;
      wdata_q        <= wdata_next;
      req_ready      <= req_ready_next;
      resp_valid     <= resp_valid_next;
      resp_error     <= resp_error_next;
      resp_rdata     <= resp_rdata_next;
      mem_addr       <= mem_addr_next;
      mem_data_input <= mem_data_input_next;
      mem_write_en   <= mem_write_en_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model,
// directed corner cases, randomized traffic and a reset-abort scenario.
module tb_load_store_unit;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_input;
  logic        mem_write_en;
  logic [63:0] mem_data_output;

  load_store_unit #(.WORDSIZE(64), .SIZE(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_addr        (mem_addr),
    .mem_data_input  (mem_data_input),
    .mem_write_en    (mem_write_en),
    .mem_data_output (mem_data_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    logic        we;
    logic [63:0] waddr;
    logic [63:0] wdata;
    int          acc;
  } exp_t;

  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wcount = 0;
  logic [63:0] last_waddr = 64'd0;
  logic [63:0] last_wdata = 64'd0;

  assign mem_data_output = (mem_addr < 64'(DEPTH)) ? mem[mem_addr[8:0]] : 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: synchronous write, records every write for the monitor.
  always @(posedge clk) begin
    if (mem_write_en) begin
      if (mem_addr < 64'(DEPTH)) mem[mem_addr[8:0]] <= mem_data_input;
      wcount     <= wcount + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_data_input;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed arithmetic on the reference memory.
  function automatic exp_t model(input logic w, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    longint unsigned idx = a >> 3;
    int off = int'(a % 8);
    int nb  = 1 << f3[1:0];
    logic legal = w ? (f3 <= 3) : (f3 <= 6);
    logic [63:0] val = 64'd0;
    logic [63:0] word;
    e.rdata = 64'd0; e.we = 1'b0; e.waddr = 64'd0; e.wdata = 64'd0; e.acc = 0;
    e.err = !legal || (off % nb != 0) || (idx >= longint'(DEPTH));
    if (e.err) begin
      e.lat = 1;
    end else if (!w) begin
      word = ref_mem[idx];
      for (int i = 0; i < nb; i++) val = val | (((word >> (8 * (off + i))) & 64'hFF) << (8 * i));
      if (f3 < 3 && nb < 8 && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
      e.rdata = val;
      e.lat   = 2;
    end else begin
      word = ref_mem[idx];
      for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx] = word;
      e.we    = 1'b1;
      e.waddr = 64'(idx);
      e.wdata = word;
      e.lat   = (nb == 8) ? 2 : 3;
    end
    return e;
  endfunction

  // Caller is at a negedge; request is held until accepted.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input bit push);
    exp_t e;
    int n = 0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      e = model(w, f3, a, wd);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares each response against the head of the scoreboard.
  initial begin
    exp_t e;
    int wbase = 0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: resp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          check("resp_error", 64'(resp_error), 64'(e.err));
          check("resp_rdata", resp_rdata, e.rdata);
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          check("write_count", 64'(wcount - wbase), 64'(e.we));
          if (e.we) begin
            check("write_addr", last_waddr, e.waddr);
            check("write_data", last_wdata, e.wdata);
          end
        end
        wbase = wcount;
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [2:0]  f3;
    logic        w;
    int          idx;
    int          n;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[0] = 64'd5; ref_mem[0] = 64'd5;
    mem[1] = 64'd5; ref_mem[1] = 64'd5;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_write_en", 64'(mem_write_en), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 3'b011, 64'h0, 64'h0, 1'b1);
    issue(1'b1, 3'b000, 64'h9, 64'hAB, 1'b1);
    issue(1'b0, 3'b000, 64'h9, 64'h0, 1'b1);
    issue(1'b0, 3'b100, 64'h9, 64'h0, 1'b1);
    issue(1'b0, 3'b010, 64'h2, 64'h0, 1'b1);
    issue(1'b1, 3'b010, 64'h1000, 64'h1234, 1'b1);
    issue(1'b1, 3'b111, 64'h10, 64'h55, 1'b1);
    issue(1'b0, 3'b111, 64'h10, 64'h0, 1'b1);
    issue(1'b1, 3'b011, 64'hFF8, 64'hDEAD_BEEF_0123_4567, 1'b1);
    issue(1'b0, 3'b011, 64'hFF8, 64'h0, 1'b1);
    drain();
    check("sb_word1_after_sb", mem[1], 64'h0000_0000_0000_AB05);

    for (int t = 0; t < 150; t++) begin
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(512, 600)) : int'($urandom_range(0, 15));
      w   = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = {32'd0, 29'(idx), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) < 7) a = a & ~(64'(1 << f3[1:0]) - 64'd1);
      issue(w, f3, a, {$urandom, $urandom}, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // SH aborted by reset while the write enable is up.
    issue(1'b1, 3'b001, 64'h22, 64'h7777, 1'b0);
    n = 0;
    while (!mem_write_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_store_wr", 64'(mem_write_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write_en", 64'(mem_write_en), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_word_untouched", mem[4], ref_mem[4]);

    for (int t = 0; t < 30; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 3));
      a  = {32'd0, 29'($urandom_range(0, 7)), 3'd0};
      issue(w, f3, a, {$urandom, $urandom}, 1'b1);
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== ref_mem[i]) begin
        fails++;
        $display("FAIL final_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
